// File: rtl/spi_slave_axi_mem.sv
// AXI4 slave memory that absorbs the SPI slave's AXI master traffic.
// Optional decode-error response for out-of-range bursts: define SPI_SLAVE_AXI_MEM_DECERR_EN.
module spi_slave_axi_mem #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 3,
    parameter int AXI_USER_WIDTH = 6,
    parameter int MEM_DEPTH      = 256
) (
    input  logic                          axi_aclk,
    input  logic                          axi_aresetn,

    input  logic                          axi_slave_aw_valid,
    output logic                          axi_slave_aw_ready,
    input  logic [AXI_ADDR_WIDTH-1:0]     axi_slave_aw_addr,
    input  logic [2:0]                    axi_slave_aw_prot,
    input  logic [3:0]                    axi_slave_aw_region,
    input  logic [7:0]                    axi_slave_aw_len,
    input  logic [2:0]                    axi_slave_aw_size,
    input  logic [1:0]                    axi_slave_aw_burst,
    input  logic                          axi_slave_aw_lock,
    input  logic [3:0]                    axi_slave_aw_cache,
    input  logic [3:0]                    axi_slave_aw_qos,
    input  logic [AXI_ID_WIDTH-1:0]       axi_slave_aw_id,
    input  logic [AXI_USER_WIDTH-1:0]     axi_slave_aw_user,

    input  logic                          axi_slave_w_valid,
    output logic                          axi_slave_w_ready,
    input  logic [AXI_DATA_WIDTH-1:0]     axi_slave_w_data,
    input  logic [AXI_DATA_WIDTH/8-1:0]   axi_slave_w_strb,
    input  logic [AXI_USER_WIDTH-1:0]     axi_slave_w_user,
    input  logic                          axi_slave_w_last,

    output logic                          axi_slave_b_valid,
    input  logic                          axi_slave_b_ready,
    output logic [1:0]                    axi_slave_b_resp,
    output logic [AXI_ID_WIDTH-1:0]       axi_slave_b_id,
    output logic [AXI_USER_WIDTH-1:0]     axi_slave_b_user,

    input  logic                          axi_slave_ar_valid,
    output logic                          axi_slave_ar_ready,
    input  logic [AXI_ADDR_WIDTH-1:0]     axi_slave_ar_addr,
    input  logic [2:0]                    axi_slave_ar_prot,
    input  logic [3:0]                    axi_slave_ar_region,
    input  logic [7:0]                    axi_slave_ar_len,
    input  logic [2:0]                    axi_slave_ar_size,
    input  logic [1:0]                    axi_slave_ar_burst,
    input  logic                          axi_slave_ar_lock,
    input  logic [3:0]                    axi_slave_ar_cache,
    input  logic [3:0]                    axi_slave_ar_qos,
    input  logic [AXI_ID_WIDTH-1:0]       axi_slave_ar_id,
    input  logic [AXI_USER_WIDTH-1:0]     axi_slave_ar_user,

    output logic                          axi_slave_r_valid,
    input  logic                          axi_slave_r_ready,
    output logic [AXI_DATA_WIDTH-1:0]     axi_slave_r_data,
    output logic [1:0]                    axi_slave_r_resp,
    output logic                          axi_slave_r_last,
    output logic [AXI_ID_WIDTH-1:0]       axi_slave_r_id,
    output logic [AXI_USER_WIDTH-1:0]     axi_slave_r_user
);

    localparam int STRB_WIDTH = AXI_DATA_WIDTH / 8;
    localparam int OFFS_W     = $clog2(STRB_WIDTH);
    localparam int IDX_W      = $clog2(MEM_DEPTH);

    localparam logic [IDX_W-1:0] IDX_ONE = 1;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    logic [1:0]                w_state_reg;
    logic                      aw_ready_reg;
    logic                      w_ready_reg;
    logic                      b_valid_reg;
    logic [1:0]                b_resp_reg;
    logic [AXI_ID_WIDTH-1:0]   b_id_reg;
    logic [IDX_W-1:0]          w_idx_reg;
    logic [7:0]                w_len_reg;
    logic [7:0]                w_cnt_reg;
    logic                      w_fixed_reg;
    logic                      w_err_reg;

    logic [0:0]                r_state_reg;
    logic                      ar_ready_reg;
    logic                      r_valid_reg;
    logic                      r_last_reg;
    logic [1:0]                r_resp_reg;
    logic [AXI_ID_WIDTH-1:0]   r_id_reg;
    logic [IDX_W-1:0]          r_idx_reg;
    logic [7:0]                r_len_reg;
    logic [7:0]                r_cnt_reg;
    logic                      r_fixed_reg;
    logic                      r_err_reg;

    logic                      aw_hs;
    logic                      w_hs;
    logic                      ar_hs;
    logic                      r_hs;
    logic                      aw_oor;
    logic                      ar_oor;
    logic                      mem_we;
    logic                      rd_en;
    logic                      rd_err;
    logic [IDX_W-1:0]          aw_idx;
    logic [IDX_W-1:0]          ar_idx;
    logic [IDX_W-1:0]          r_idx_next;
    logic [IDX_W-1:0]          rd_idx;
    logic [AXI_DATA_WIDTH-1:0] r_data_bus;

    assign aw_hs  = axi_slave_aw_valid && aw_ready_reg;
    assign w_hs   = axi_slave_w_valid  && w_ready_reg;
    assign ar_hs  = axi_slave_ar_valid && ar_ready_reg;
    assign r_hs   = r_valid_reg && axi_slave_r_ready;

    assign aw_idx = axi_slave_aw_addr[IDX_W+OFFS_W-1:OFFS_W];
    assign ar_idx = axi_slave_ar_addr[IDX_W+OFFS_W-1:OFFS_W];

`ifdef SPI_SLAVE_AXI_MEM_DECERR_EN
    assign aw_oor = |(axi_slave_aw_addr >> (IDX_W + OFFS_W));
    assign ar_oor = |(axi_slave_ar_addr >> (IDX_W + OFFS_W));
`else
    assign aw_oor = 1'b0;
    assign ar_oor = 1'b0;
`endif

    // Write channel: address latch, beat stream, single response.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            w_state_reg  <= W_IDLE;
            aw_ready_reg <= 1'b0;
            w_ready_reg  <= 1'b0;
            b_valid_reg  <= 1'b0;
            b_resp_reg   <= RESP_OKAY;
            b_id_reg     <= '0;
            w_idx_reg    <= '0;
            w_len_reg    <= '0;
            w_cnt_reg    <= '0;
            w_fixed_reg  <= 1'b0;
            w_err_reg    <= 1'b0;
        end else begin
            case (w_state_reg)
                W_IDLE: begin
                    aw_ready_reg <= 1'b1;
                    if (aw_hs) begin
                        aw_ready_reg <= 1'b0;
                        w_ready_reg  <= 1'b1;
                        w_idx_reg    <= aw_idx;
                        w_len_reg    <= axi_slave_aw_len;
                        w_cnt_reg    <= '0;
                        w_fixed_reg  <= (axi_slave_aw_burst == BURST_FIXED);
                        w_err_reg    <= aw_oor;
                        b_id_reg     <= axi_slave_aw_id;
                        w_state_reg  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        if (!w_fixed_reg) begin
                            w_idx_reg <= w_idx_reg + IDX_ONE;
                        end
                        w_cnt_reg <= w_cnt_reg + 8'd1;
                        if (axi_slave_w_last || (w_cnt_reg == w_len_reg)) begin
                            w_ready_reg <= 1'b0;
                            b_valid_reg <= 1'b1;
                            b_resp_reg  <= w_err_reg ? RESP_DECERR : RESP_OKAY;
                            w_state_reg <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (axi_slave_b_ready) begin
                        b_valid_reg  <= 1'b0;
                        aw_ready_reg <= 1'b1;
                        w_state_reg  <= W_IDLE;
                    end
                end
                default: begin
                    w_state_reg <= W_IDLE;
                end
            endcase
        end
    end

    assign mem_we = w_hs && !w_err_reg;

    // The memory fetch for the next beat is launched on the handshake of the current one.
    assign r_idx_next = r_fixed_reg ? r_idx_reg : (r_idx_reg + IDX_ONE);
    assign rd_en      = ar_hs || (r_hs && !r_last_reg);
    assign rd_idx     = ar_hs ? ar_idx : r_idx_next;
    assign rd_err     = ar_hs ? ar_oor : r_err_reg;

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_state_reg  <= R_IDLE;
            ar_ready_reg <= 1'b0;
            r_valid_reg  <= 1'b0;
            r_last_reg   <= 1'b0;
            r_resp_reg   <= RESP_OKAY;
            r_id_reg     <= '0;
            r_idx_reg    <= '0;
            r_len_reg    <= '0;
            r_cnt_reg    <= '0;
            r_fixed_reg  <= 1'b0;
            r_err_reg    <= 1'b0;
        end else begin
            case (r_state_reg)
                R_IDLE: begin
                    ar_ready_reg <= 1'b1;
                    if (ar_hs) begin
                        ar_ready_reg <= 1'b0;
                        r_valid_reg  <= 1'b1;
                        r_last_reg   <= (axi_slave_ar_len == 8'd0);
                        r_resp_reg   <= ar_oor ? RESP_DECERR : RESP_OKAY;
                        r_id_reg     <= axi_slave_ar_id;
                        r_idx_reg    <= ar_idx;
                        r_len_reg    <= axi_slave_ar_len;
                        r_cnt_reg    <= '0;
                        r_fixed_reg  <= (axi_slave_ar_burst == BURST_FIXED);
                        r_err_reg    <= ar_oor;
                        r_state_reg  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_hs) begin
                        if (r_last_reg) begin
                            r_valid_reg  <= 1'b0;
                            r_last_reg   <= 1'b0;
                            ar_ready_reg <= 1'b1;
                            r_state_reg  <= R_IDLE;
                        end else begin
                            r_idx_reg  <= r_idx_next;
                            r_cnt_reg  <= r_cnt_reg + 8'd1;
                            r_last_reg <= ((r_cnt_reg + 8'd1) == r_len_reg);
                        end
                    end
                end
                default: begin
                    r_state_reg <= R_IDLE;
                end
            endcase
        end
    end

    // One byte-wide array per lane keeps byte enables trivial; contents survive reset.
    for (genvar gi = 0; gi < STRB_WIDTH; gi++) begin : g_lane
        logic [7:0] lane_mem [MEM_DEPTH];
        logic [7:0] lane_q_reg;

        always_ff @(posedge axi_aclk) begin
            if (mem_we && axi_slave_w_strb[gi]) begin
                lane_mem[w_idx_reg] <= axi_slave_w_data[gi*8 +: 8];
            end
        end

        always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
            if (!axi_aresetn) begin
                lane_q_reg <= 8'h00;
            end else if (rd_en) begin
                lane_q_reg <= rd_err ? 8'h00 : lane_mem[rd_idx];
            end
        end

        assign r_data_bus[gi*8 +: 8] = lane_q_reg;
    end

    assign axi_slave_aw_ready = aw_ready_reg;
    assign axi_slave_w_ready  = w_ready_reg;
    assign axi_slave_b_valid  = b_valid_reg;
    assign axi_slave_b_resp   = b_resp_reg;
    assign axi_slave_b_id     = b_id_reg;
    assign axi_slave_b_user   = '0;
    assign axi_slave_ar_ready = ar_ready_reg;
    assign axi_slave_r_valid  = r_valid_reg;
    assign axi_slave_r_data   = r_data_bus;
    assign axi_slave_r_resp   = r_resp_reg;
    assign axi_slave_r_last   = r_last_reg;
    assign axi_slave_r_id     = r_id_reg;
    assign axi_slave_r_user   = '0;

    logic unused_inputs;
    assign unused_inputs = ^{axi_slave_aw_addr, axi_slave_aw_prot, axi_slave_aw_region,
                             axi_slave_aw_size, axi_slave_aw_lock, axi_slave_aw_cache,
                             axi_slave_aw_qos, axi_slave_aw_user, axi_slave_w_user,
                             axi_slave_ar_addr, axi_slave_ar_prot, axi_slave_ar_region,
                             axi_slave_ar_size, axi_slave_ar_lock, axi_slave_ar_cache,
                             axi_slave_ar_qos, axi_slave_ar_user};

endmodule

// File: tb/tb_spi_slave_axi_mem.sv
// Scoreboard bench for spi_slave_axi_mem: stimulus pushes expected B/R responses, a monitor pops and compares.
module tb_spi_slave_axi_mem;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int IW = 3;
    localparam int UW = 6;
    localparam int DEPTH = 256;
    localparam logic [1:0] INCR  = 2'b01;
    localparam logic [1:0] FIXED = 2'b00;
`ifdef SPI_SLAVE_AXI_MEM_DECERR_EN
    localparam bit DEC = 1'b1;
`else
    localparam bit DEC = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic          aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready;
    logic [AW-1:0] aw_addr, ar_addr;
    logic [7:0]    aw_len, ar_len;
    logic [1:0]    aw_burst, ar_burst, b_resp, r_resp;
    logic [IW-1:0] aw_id, ar_id, b_id, r_id;
    logic [DW-1:0] w_data, r_data;
    logic [7:0]    w_strb;
    logic [UW-1:0] b_user, r_user;
    logic          ar_valid, ar_ready, r_valid, r_ready, r_last;

    spi_slave_axi_mem #(
        .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW),
        .AXI_USER_WIDTH(UW), .MEM_DEPTH(DEPTH)
    ) dut (
        .axi_aclk(clk), .axi_aresetn(rst_n),
        .axi_slave_aw_valid(aw_valid), .axi_slave_aw_ready(aw_ready), .axi_slave_aw_addr(aw_addr),
        .axi_slave_aw_prot(3'd0), .axi_slave_aw_region(4'd0), .axi_slave_aw_len(aw_len),
        .axi_slave_aw_size(3'd3), .axi_slave_aw_burst(aw_burst), .axi_slave_aw_lock(1'b0),
        .axi_slave_aw_cache(4'd0), .axi_slave_aw_qos(4'd0), .axi_slave_aw_id(aw_id),
        .axi_slave_aw_user(6'd0),
        .axi_slave_w_valid(w_valid), .axi_slave_w_ready(w_ready), .axi_slave_w_data(w_data),
        .axi_slave_w_strb(w_strb), .axi_slave_w_user(6'd0), .axi_slave_w_last(w_last),
        .axi_slave_b_valid(b_valid), .axi_slave_b_ready(b_ready), .axi_slave_b_resp(b_resp),
        .axi_slave_b_id(b_id), .axi_slave_b_user(b_user),
        .axi_slave_ar_valid(ar_valid), .axi_slave_ar_ready(ar_ready), .axi_slave_ar_addr(ar_addr),
        .axi_slave_ar_prot(3'd0), .axi_slave_ar_region(4'd0), .axi_slave_ar_len(ar_len),
        .axi_slave_ar_size(3'd3), .axi_slave_ar_burst(ar_burst), .axi_slave_ar_lock(1'b0),
        .axi_slave_ar_cache(4'd0), .axi_slave_ar_qos(4'd0), .axi_slave_ar_id(ar_id),
        .axi_slave_ar_user(6'd0),
        .axi_slave_r_valid(r_valid), .axi_slave_r_ready(r_ready), .axi_slave_r_data(r_data),
        .axi_slave_r_resp(r_resp), .axi_slave_r_last(r_last), .axi_slave_r_id(r_id),
        .axi_slave_r_user(r_user)
    );

    typedef struct packed { logic [1:0] resp; logic [IW-1:0] id; } b_exp_t;
    typedef struct packed { logic [DW-1:0] data; logic [1:0] resp; logic last; logic [IW-1:0] id; } r_exp_t;

    b_exp_t b_q[$];
    r_exp_t r_q[$];
    logic [DW-1:0] wdat [16];
    logic [7:0]    wstb [16];
    logic [DW-1:0] rdat [16];
    bit toggle_mode = 1'b0;
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    function automatic logic sel_ready(input int sel);
        case (sel)
            0:       return aw_ready;
            1:       return w_ready;
            default: return ar_ready;
        endcase
    endfunction

    task automatic wait_ready(input int sel, input string nm);
        bit ok = 1'b0;
        for (int c = 0; c < 300 && !ok; c++) begin
            @(negedge clk);
            if (sel_ready(sel)) ok = 1'b1;
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL %s_timeout: ready got 0 required 1", nm);
        end
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                             input logic [IW-1:0] id, input int nbeats, input logic [1:0] resp,
                             input bit expect_b);
        b_exp_t e;
        if (expect_b) begin
            e.resp = resp; e.id = id;
            b_q.push_back(e);
        end
        @(posedge clk); #1;
        aw_valid = 1'b1; aw_addr = addr; aw_len = len; aw_burst = burst; aw_id = id;
        wait_ready(0, "aw");
        @(posedge clk); #1;
        aw_valid = 1'b0;
        for (int k = 0; k < nbeats; k++) begin
            w_valid = 1'b1; w_data = wdat[k]; w_strb = wstb[k]; w_last = (k == int'(len));
            wait_ready(1, "w");
            @(posedge clk); #1;
        end
        w_valid = 1'b0; w_last = 1'b0;
        if (expect_b) check("b_latency", {63'd0, b_valid}, 64'd1);
        $display("write addr=%h len=%0d burst=%0d id=%0d beats=%0d", addr, len, burst, id, nbeats);
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [IW-1:0] id, input logic [1:0] resp);
        r_exp_t e;
        for (int k = 0; k <= int'(len); k++) begin
            e.data = rdat[k]; e.resp = resp; e.last = (k == int'(len)); e.id = id;
            r_q.push_back(e);
        end
        @(posedge clk); #1;
        ar_valid = 1'b1; ar_addr = addr; ar_len = len; ar_burst = burst; ar_id = id;
        wait_ready(2, "ar");
        @(posedge clk); #1;
        ar_valid = 1'b0;
        check("r_first_latency", {63'd0, r_valid}, 64'd1);
        $display("read  addr=%h len=%0d burst=%0d id=%0d", addr, len, burst, id);
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int c = 0; c < 600 && !ok; c++) begin
            @(negedge clk);
            if (r_q.size() == 0 && b_q.size() == 0 && !r_valid && !b_valid) ok = 1'b1;
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL drain_timeout: pending r=%0d b=%0d required 0", r_q.size(), b_q.size());
        end
    endtask

    initial begin
        r_ready = 1'b1; b_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (toggle_mode) begin
                r_ready = ~r_ready; b_ready = ~b_ready;
            end else begin
                r_ready = 1'b1; b_ready = 1'b1;
            end
        end
    end

    initial begin : monitor
        r_exp_t re;
        b_exp_t be;
        bit stall_r = 1'b0;
        bit stall_b = 1'b0;
        logic [DW-1:0] held_d;
        logic [3:0]    held_rm;
        logic [4:0]    held_b;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_r = 1'b0; stall_b = 1'b0;
            end else begin
                if (stall_r && r_valid) begin
                    check("r_data_stable", r_data, held_d);
                    check("r_ctrl_stable", {60'd0, r_resp, r_last, 1'b1}, {60'd0, held_rm});
                end
                if (stall_b && b_valid) check("b_stable", {59'd0, b_resp, b_id}, {59'd0, held_b});
                if (r_valid && r_ready) begin
                    if (r_q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL r_unexpected: beat %h arrived, required none", r_data);
                    end else begin
                        re = r_q.pop_front();
                        check("r_data", r_data, re.data);
                        check("r_resp", {62'd0, r_resp}, {62'd0, re.resp});
                        check("r_last", {63'd0, r_last}, {63'd0, re.last});
                        check("r_id", {61'd0, r_id}, {61'd0, re.id});
                    end
                end
                if (b_valid && b_ready) begin
                    if (b_q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL b_unexpected: b_id %0d arrived, required none", b_id);
                    end else begin
                        be = b_q.pop_front();
                        check("b_resp", {62'd0, b_resp}, {62'd0, be.resp});
                        check("b_id", {61'd0, b_id}, {61'd0, be.id});
                    end
                end
                stall_r = r_valid && !r_ready;
                held_d  = r_data;
                held_rm = {r_resp, r_last, 1'b1};
                stall_b = b_valid && !b_ready;
                held_b  = {b_resp, b_id};
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        aw_valid = 1'b0; aw_addr = '0; aw_len = '0; aw_burst = INCR; aw_id = '0;
        w_valid = 1'b0; w_data = '0; w_strb = '0; w_last = 1'b0;
        ar_valid = 1'b0; ar_addr = '0; ar_len = '0; ar_burst = INCR; ar_id = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_aw_ready", {63'd0, aw_ready}, 64'd0);
        check("rst_ar_ready", {63'd0, ar_ready}, 64'd0);
        check("rst_w_ready", {63'd0, w_ready}, 64'd0);
        check("rst_b_valid", {63'd0, b_valid}, 64'd0);
        check("rst_r_valid", {63'd0, r_valid}, 64'd0);
        check("rst_r_last", {63'd0, r_last}, 64'd0);
        check("rst_r_data", r_data, 64'd0);
        check("rst_resp_ids", {54'd0, b_resp, r_resp, b_id, r_id}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_aw_ready", {63'd0, aw_ready}, 64'd1);
        check("post_rst_ar_ready", {63'd0, ar_ready}, 64'd1);

        // single beat
        wdat[0] = 64'h1122_3344_5566_7788; wstb[0] = 8'hFF;
        axi_write(32'h10, 8'd0, INCR, 3'd5, 1, 2'b00, 1'b1);
        drain();
        rdat[0] = 64'h1122_3344_5566_7788;
        axi_read(32'h10, 8'd0, INCR, 3'd5, 2'b00);
        drain();

        // INCR across the top of memory: words 254,255,0,1
        wdat[0] = 64'hAAAA_0000_0000_00FE; wdat[1] = 64'hAAAA_0000_0000_00FF;
        wdat[2] = 64'hAAAA_0000_0000_0000; wdat[3] = 64'hAAAA_0000_0000_0001;
        for (int k = 0; k < 4; k++) wstb[k] = 8'hFF;
        axi_write(32'h7F0, 8'd3, INCR, 3'd2, 4, 2'b00, 1'b1);
        drain();
        for (int k = 0; k < 4; k++) rdat[k] = wdat[k];
        axi_read(32'h7F0, 8'd3, INCR, 3'd3, 2'b00);
        drain();
        rdat[0] = 64'hAAAA_0000_0000_0000; rdat[1] = 64'hAAAA_0000_0000_0001;
        axi_read(32'h0, 8'd1, INCR, 3'd4, 2'b00);
        drain();

        // partial strobe on word 0
        wdat[0] = 64'hFFFF_FFFF_FFFF_FFFF; wstb[0] = 8'h0F;
        axi_write(32'h0, 8'd0, INCR, 3'd4, 1, 2'b00, 1'b1);
        drain();
        rdat[0] = 64'hAAAA_0000_FFFF_FFFF;
        axi_read(32'h0, 8'd0, INCR, 3'd1, 2'b00);
        drain();

        // FIXED burst: all three beats land on word 16
        wdat[0] = 64'h0F0F_0F0F_0000_0001; wdat[1] = 64'h0F0F_0F0F_0000_0002;
        wdat[2] = 64'h0F0F_0F0F_0000_0003;
        for (int k = 0; k < 3; k++) wstb[k] = 8'hFF;
        axi_write(32'h80, 8'd2, FIXED, 3'd3, 3, 2'b00, 1'b1);
        drain();
        rdat[0] = 64'h0F0F_0F0F_0000_0003;
        axi_read(32'h80, 8'd0, INCR, 3'd3, 2'b00);
        drain();

        // out-of-range start address
        rdat[0] = DEC ? 64'd0 : 64'hAAAA_0000_FFFF_FFFF;
        rdat[1] = DEC ? 64'd0 : 64'hAAAA_0000_0000_0001;
        axi_read(32'h1000, 8'd1, INCR, 3'd1, DEC ? 2'b11 : 2'b00);
        drain();
        wdat[0] = 64'hDEAD_BEEF_0000_0000; wstb[0] = 8'hFF;
        axi_write(32'h1000, 8'd0, INCR, 3'd4, 1, DEC ? 2'b11 : 2'b00, 1'b1);
        drain();
        rdat[0] = DEC ? 64'hAAAA_0000_FFFF_FFFF : 64'hDEAD_BEEF_0000_0000;
        axi_read(32'h0, 8'd0, INCR, 3'd0, 2'b00);
        drain();

        // stalled read with a concurrent write burst elsewhere
        for (int k = 0; k < 8; k++) begin
            wdat[k] = 64'h0000_0000_0000_1000 + 64'(k); wstb[k] = 8'hFF; rdat[k] = wdat[k];
        end
        axi_write(32'h40, 8'd7, INCR, 3'd1, 8, 2'b00, 1'b1);
        drain();
        toggle_mode = 1'b1;
        fork
            axi_read(32'h40, 8'd7, INCR, 3'd2, 2'b00);
            begin
                for (int k = 0; k < 4; k++) wdat[k] = 64'h0000_0000_0000_2000 + 64'(k);
                axi_write(32'h200, 8'd3, INCR, 3'd6, 4, 2'b00, 1'b1);
            end
        join
        drain();
        toggle_mode = 1'b0;
        for (int k = 0; k < 4; k++) rdat[k] = 64'h0000_0000_0000_2000 + 64'(k);
        axi_read(32'h200, 8'd3, INCR, 3'd6, 2'b00);
        drain();

        // reset in the middle of a len=7 write after three beats
        for (int k = 0; k < 3; k++) begin
            wdat[k] = 64'h0000_0000_0000_5000 + 64'(k); wstb[k] = 8'hFF;
        end
        axi_write(32'h100, 8'd7, INCR, 3'd7, 3, 2'b00, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_aw_ready", {63'd0, aw_ready}, 64'd0);
        check("midrst_w_ready", {63'd0, w_ready}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_release_aw_ready", {63'd0, aw_ready}, 64'd1);
        check("midrst_release_w_ready", {63'd0, w_ready}, 64'd0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("midrst_no_b_valid", {63'd0, b_valid}, 64'd0);
        end
        for (int k = 0; k < 3; k++) rdat[k] = 64'h0000_0000_0000_5000 + 64'(k);
        axi_read(32'h100, 8'd2, INCR, 3'd7, 2'b00);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
